// File: rtl/r5_pkg.sv
// r5_pkg: shared constants and types for the radix-5 FFT stage controller.
// Holds the radix, default stage geometry, group-index type and FSM states.
package r5_pkg;

  localparam int R5_RADIX = 5;
  localparam int R5_SPAN  = 5;
  localparam int R5_LAT   = 10;
  localparam int R5_TW_AW = 5;

  typedef logic [2:0] grp_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } st_e;

endpackage

// File: rtl/r5_vld_dly.sv
// r5_vld_dly: LAT-deep 1-bit shift line with synchronous active-high reset.
// Ports: clk, rst, d_i (marker in), q_o (marker out after LAT edges).
module r5_vld_dly #(
  parameter int LAT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [LAT-1:0] sh_q;

  generate
    if (LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (rst) sh_q <= '0;
        else     sh_q <= d_i;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (rst) sh_q <= '0;
        else     sh_q <= {sh_q[LAT-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = sh_q[LAT-1];

endmodule

// File: rtl/r5_stage_ctrl.sv
// r5_stage_ctrl: sequencer for one radix-5 FFT stage (frame = 5*SPAN samples).
// In: clk, rst, in_valid, in_sop. Out: sel, bf_en, tw_addr, out_valid,
// out_sop, busy, err_sop. Control outputs lag acceptance by one edge;
// markers appear LAT edges after the acceptance edge.
module r5_stage_ctrl
  import r5_pkg::*;
#(
  parameter int SPAN  = R5_SPAN,
  parameter int LAT   = R5_LAT,
  parameter int TW_AW = R5_TW_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic [2:0]       sel,
  output logic             bf_en,
  output logic [TW_AW-1:0] tw_addr,
  output logic             out_valid,
  output logic             out_sop,
  output logic             busy,
  output logic             err_sop
);

  localparam int IW = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(SPAN - 1);
  localparam grp_t GRP_LAST = grp_t'(R5_RADIX - 1);

  st_e             st_q, st_d;
  logic [IW-1:0]   idx_q, idx_d;
  grp_t            grp_q, grp_d;

  logic            acc;
  grp_t            cur_g;
  logic [IW-1:0]   cur_i;
  logic [TW_AW-1:0] prod;

  grp_t            sel_q;
  logic            bf_q;
  logic [TW_AW-1:0] tw_q;
  logic            err_q;
  logic            acc_q;
  logic            sop_q;

  // Counters hold the position of the next expected sample; an accepted
  // sop overrides them so that sample is always (0,0).
  always_comb begin
    acc   = in_valid & ((st_q == RUN) | in_sop);
    cur_g = in_sop ? '0 : grp_q;
    cur_i = in_sop ? '0 : idx_q;
    prod  = TW_AW'(cur_g) * TW_AW'(cur_i);
    st_d  = st_q;
    idx_d = idx_q;
    grp_d = grp_q;
    if (acc) begin
      st_d = RUN;
      if (cur_i == IDX_LAST) begin
        idx_d = '0;
        if (cur_g == GRP_LAST) begin
          grp_d = '0;
          st_d  = IDLE;
        end else begin
          grp_d = cur_g + 3'd1;
        end
      end else begin
        idx_d = cur_i + 1'b1;
        grp_d = cur_g;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      idx_q <= '0;
      grp_q <= '0;
    end else begin
      st_q  <= st_d;
      idx_q <= idx_d;
      grp_q <= grp_d;
    end
  end

  // Markers are retimed together with the control registers so the
  // shift line output lands exactly LAT edges after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      bf_q  <= 1'b0;
      tw_q  <= '0;
      err_q <= 1'b0;
      acc_q <= 1'b0;
      sop_q <= 1'b0;
    end else begin
      bf_q  <= acc & (cur_g == GRP_LAST);
      err_q <= in_valid & in_sop & (st_q == RUN);
      acc_q <= acc;
      sop_q <= acc & in_sop;
      if (acc) begin
        sel_q <= cur_g;
        tw_q  <= prod;
      end
    end
  end

  r5_vld_dly #(.LAT(LAT)) u_vld (
    .clk (clk),
    .rst (rst),
    .d_i (acc_q),
    .q_o (out_valid)
  );

  r5_vld_dly #(.LAT(LAT)) u_sop (
    .clk (clk),
    .rst (rst),
    .d_i (sop_q),
    .q_o (out_sop)
  );

  assign sel     = sel_q;
  assign bf_en   = bf_q;
  assign tw_addr = tw_q;
  assign err_sop = err_q;
  assign busy    = (st_q == RUN);

endmodule

// File: tb/tb_r5_stage_ctrl.sv
// tb_r5_stage_ctrl: scenario bench for r5_stage_ctrl with a behavioural
// model for control outputs and a marker queue for out_valid/out_sop.
module tb_r5_stage_ctrl;

  localparam int SPAN  = 5;
  localparam int LAT   = 10;
  localparam int TW_AW = 5;
  localparam int FR    = 5 * SPAN;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_sop = 1'b0;
  logic [2:0]       sel;
  logic             bf_en;
  logic [TW_AW-1:0] tw_addr;
  logic             out_valid;
  logic             out_sop;
  logic             busy;
  logic             err_sop;

  r5_stage_ctrl #(
    .SPAN  (SPAN),
    .LAT   (LAT),
    .TW_AW (TW_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .sel       (sel),
    .bf_en     (bf_en),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .busy      (busy),
    .err_sop   (err_sop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int   due;
    logic sop;
  } mk_t;

  mk_t q[$];

  logic             m_run = 1'b0;
  int               m_pos = 0;
  logic [2:0]       m_sel = '0;
  logic             m_bf  = 1'b0;
  logic [TW_AW-1:0] m_tw  = '0;
  logic             m_err = 1'b0;

  wire  [10:0] obs = {sel, bf_en, tw_addr, busy, err_sop};
  logic [10:0] exp_c;
  assign exp_c = {m_sel, m_bf, m_tw, m_run, m_err};

  // Drive one cycle, update the model at the edge, return at negedge.
  task automatic drive(input logic v, input logic s, input logic r);
    int p;
    int g;
    int i;
    in_valid = v;
    in_sop   = s;
    rst      = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_run = 1'b0;
      m_pos = 0;
      m_sel = '0;
      m_bf  = 1'b0;
      m_tw  = '0;
      m_err = 1'b0;
      q.delete();
    end else begin
      m_err = v && s && m_run;
      m_bf  = 1'b0;
      if (v && (m_run || s)) begin
        p = s ? 0 : m_pos;
        g = p / SPAN;
        i = p % SPAN;
        m_sel = 3'(g);
        m_bf  = (g == 4);
        m_tw  = TW_AW'(g * i);
        q.push_back('{due: cyc + LAT, sop: s});
        if (p == FR - 1) begin
          m_pos = 0;
          m_run = 1'b0;
        end else begin
          m_pos = p + 1;
          m_run = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  // Marker scoreboard: pops an entry when its due cycle comes round.
  always @(negedge clk) begin
    logic ev;
    logic es;
    ev = (q.size() > 0) && (q[0].due == cyc);
    es = ev && q[0].sop;
    total++;
    if (out_valid !== ev || out_sop !== es) begin
      bad++;
      $display("FAIL marker cyc=%0d got v=%b s=%b want v=%b s=%b",
               cyc, out_valid, out_sop, ev, es);
    end
    if (ev) void'(q.pop_front());
  end

  task automatic drain();
    for (int k = 0; k < LAT + 3; k++) begin
      drive(1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== exp_c) begin
        bad++;
        $display("FAIL drain k=%0d got %h want %h", k, obs, exp_c);
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_ctrl got %h want 0", obs);
    end
    total++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0) begin
      bad++;
      $display("FAIL reset_mark got %b%b want 00", out_valid, out_sop);
    end
  endtask

  task automatic test_frame();
    for (int k = 0; k < FR; k++) begin
      drive(1'b1, k == 0, 1'b0);
      total++;
      if (obs !== exp_c) begin
        bad++;
        $display("FAIL frame k=%0d got %h want %h", k, obs, exp_c);
      end
      total++;
      if (sel !== 3'(k / 5)) begin
        bad++;
        $display("FAIL frame_sel k=%0d got %0d want %0d", k, sel, k / 5);
      end
      if (k >= 20) begin
        total++;
        if (bf_en !== 1'b1 || tw_addr !== TW_AW'(4 * (k - 20))) begin
          bad++;
          $display("FAIL frame_tw k=%0d got bf=%b tw=%0d want bf=1 tw=%0d",
                   k, bf_en, tw_addr, 4 * (k - 20));
        end
      end
      if (k == FR - 1) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL frame_busy got %b want 0", busy);
        end
      end
    end
    drain();
  endtask

  task automatic test_bubbles();
    for (int k = 0; k < FR; k++) begin
      drive(1'b1, k == 0, 1'b0);
      total++;
      if (obs !== exp_c) begin
        bad++;
        $display("FAIL bubble_v k=%0d got %h want %h", k, obs, exp_c);
      end
      drive(1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== exp_c || bf_en !== 1'b0) begin
        bad++;
        $display("FAIL bubble_h k=%0d got %h want %h", k, obs, exp_c);
      end
    end
    drain();
  endtask

  task automatic test_idle_ignore();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== exp_c || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle k=%0d got %h want %h", k, obs, exp_c);
      end
    end
  endtask

  task automatic test_mid_sop();
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 1; k < 7; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== exp_c) begin
        bad++;
        $display("FAIL midsop_pre k=%0d got %h want %h", k, obs, exp_c);
      end
    end
    drive(1'b1, 1'b1, 1'b0);
    total++;
    if (err_sop !== 1'b1 || sel !== 3'd0 || tw_addr !== '0) begin
      bad++;
      $display("FAIL midsop_err got err=%b sel=%0d tw=%0d want 1 0 0",
               err_sop, sel, tw_addr);
    end
    for (int k = 1; k < FR; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== exp_c) begin
        bad++;
        $display("FAIL midsop_run k=%0d got %h want %h", k, obs, exp_c);
      end
      if (k == 1) begin
        total++;
        if (err_sop !== 1'b0) begin
          bad++;
          $display("FAIL midsop_pulse got %b want 0", err_sop);
        end
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL midsop_end got busy=%b want 0", busy);
    end
    drain();
  endtask

  task automatic test_reset_abort();
    for (int k = 0; k < 12; k++) drive(1'b1, k == 0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    total++;
    if (obs !== 11'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort got %h v=%b want 0 0", obs, out_valid);
    end
    drain();
    for (int k = 0; k < FR; k++) begin
      drive(1'b1, k == 0, 1'b0);
      total++;
      if (obs !== exp_c) begin
        bad++;
        $display("FAIL abort_new k=%0d got %h want %h", k, obs, exp_c);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2 * FR; k++) begin
      drive(1'b1, (k % FR) == 0, 1'b0);
      total++;
      if (obs !== exp_c || err_sop !== 1'b0) begin
        bad++;
        $display("FAIL b2b k=%0d got %h want %h", k, obs, exp_c);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bubbles();
    test_idle_ignore();
    test_mid_sop();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r5_stage_ctrl.md
Name: r5_stage_ctrl

Overview:
- Sequencing controller for one radix-5 FFT pipeline stage.
- Tracks sample position in each frame of 5*SPAN complex samples.
- Drives the stage's group select, butterfly enable and twiddle address.
- Carries a valid/start-of-frame marker through a shift line matched to the fixed-latency complex delay buffers (10-cycle default), so downstream logic knows when buffer outputs are meaningful.

Parameters:
- SPAN, 5: samples per group; frame length is 5*SPAN; equals the stage's feedback delay depth.
- LAT, 10: datapath latency in clk cycles from accepted input to stage output; equals the delay-buffer depth.
- TW_AW, 5: twiddle address width; must satisfy 2^TW_AW > 4*(SPAN-1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input sample present this cycle
- in_sop  in  1  first sample of a frame; qualified by in_valid
- sel  out  3  group index 0..4 of the last accepted sample
- bf_en  out  1  butterfly compute enable; high for group 4 samples
- tw_addr  out  TW_AW  twiddle ROM address = group*idx
- out_valid  out  1  stage output valid, LAT cycles after acceptance
- out_sop  out  1  stage output first sample, LAT cycles after in_sop acceptance
- busy  out  1  frame in progress (state RUN)
- err_sop  out  1  one-cycle pulse: in_sop arrived mid-frame

Behaviour:
- Reset (rst=1 at a clk edge):
  - all outputs go to 0.
  - idx=0, grp=0, state=IDLE.
  - valid and sop delay lines cleared.
  - Applies mid-frame too: partial frame is discarded, nothing is emitted after reset.
- Acceptance: a sample is accepted when in_valid=1 and either state=RUN or in_sop=1.
  - In IDLE, in_valid without in_sop is ignored: no counter motion, no marker.
- Counters (idx 0..SPAN-1, grp 0..4) advance only on acceptance.
  - in_valid=0 holds all state (bubble); the frame resumes on the next valid sample.
  - Accepted sample with in_sop=1: it is sample (grp=0, idx=0). Next state is RUN, or IDLE if SPAN*5==1.
  - Otherwise: idx increments; when idx==SPAN-1 it wraps to 0 and grp increments.
  - Last sample (grp=4, idx=SPAN-1): counters wrap to 0, state goes to IDLE.
  - A back-to-back in_sop on the very next cycle is legal and accepted.
- Mid-frame sop: in_sop=1 with in_valid=1 while state=RUN.
  - err_sop pulses high for exactly 1 cycle, registered.
  - The frame restarts: this sample becomes (0,0).
  - The old partial frame's markers already in the delay line are not cancelled.
- Control outputs are registered, with latency 1 from acceptance. On the edge following acceptance of sample (g,i): sel=g, bf_en=(g==4), tw_addr=g*i.
  - Product is unsigned, at most 4*(SPAN-1), zero-extended to TW_AW.
  - On non-accepted cycles sel/tw_addr hold their values and bf_en=0.
- Marker lines: LAT-stage shift registers, free-running every cycle with no enable, matching the buffers.
  - Line input is (accepted, accepted & in_sop).
  - out_valid/out_sop are high exactly LAT cycles after the acceptance edge.
- busy = (state==RUN), registered.
- Simultaneous rst and any input: rst wins.

Decomposition:
- Shared package r5_pkg holds:
  - R5_RADIX=5
  - default SPAN/LAT constants
  - a 3-bit group-index typedef
- Natural sub-module: r5_vld_dly. It is a LAT-deep, 1-bit wide, synchronous-reset shift line, instantiated twice (valid, sop). It is reusable wherever a buffer of LAT cycles needs a matching valid.

Test Plan:
- Defaults; reset, then in_sop+in_valid for 1 cycle, then 24 further valid cycles:
  - sel steps 0,0,0,0,0,1…4; bf_en high on cycles 21-25 after start.
  - tw_addr for the last 5 samples is 0,4,8,12,16.
  - busy falls after sample 25.
  - out_valid high for 25 cycles starting 10 cycles after the first acceptance edge; out_sop on its first cycle only.
- Same frame with in_valid=0 every other cycle:
  - counters hold during bubbles; 25 samples total.
  - out_valid reproduces the same gapped pattern delayed by exactly 10 cycles.
- in_valid=1 for 8 cycles in IDLE without in_sop → no sel change, out_valid stays 0, busy=0.
- in_sop at sample 7 of a frame → err_sop=1 for one cycle; sel=0, tw_addr=0 next cycle; a full 25-sample frame then completes from that point.
- Assert rst at sample 12, then release → all outputs 0; out_valid never asserts for the aborted samples; a fresh in_sop starts cleanly.
- Two frames back-to-back (in_sop on cycle 26) → no err_sop; out_sop pulses exactly 25 cycles apart; out_valid continuous for 50 cycles.
